// File: rtl/ysyx_22041405_mdu.sv
// Iterative multiply/divide unit for the RV M-extension: radix-2 shift-add
// multiplier and restoring divider behind valid/ready handshakes.
module ysyx_22041405_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   b_q, b_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;   // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;   // multiplier bits / quotient bits
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               signed_a, signed_b, s1, s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    s1       = src1[WIDTH-1];
    s2       = src2[WIDTH-1];
    // MULH, MULHSU, DIV, REM treat src1 as signed; MULH, DIV, REM also src2.
    signed_a = (mdu_op == 3'b001) || (mdu_op == 3'b010) || (mdu_op == 3'b100) || (mdu_op == 3'b110);
    signed_b = (mdu_op == 3'b001) || (mdu_op == 3'b100) || (mdu_op == 3'b110);
    abs1     = (signed_a && s1) ? -src1 : src1;
    abs2     = (signed_b && s2) ? -src2 : src2;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod      = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo       = neg_q ? -lo_q : lo_q;
    rem       = neg_q ? -hi_q : hi_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_d = mdu_op;
            if (mdu_op[2] && src2 == '0) begin
              result_d = mdu_op[1] ? src1 : '1;
              state_d  = S_DONE;
            end else if (mdu_op[2] && !mdu_op[0] && src1 == MIN_NEG && src2 == '1) begin
              result_d = mdu_op[1] ? '0 : src1;
              state_d  = S_DONE;
            end else begin
              unique case (mdu_op)
                3'b001, 3'b100: neg_d = s1 ^ s2;
                3'b010, 3'b110: neg_d = s1;
                default:        neg_d = 1'b0;
              endcase
              hi_d    = '0;
              lo_d    = mdu_op[2] ? abs1 : abs2;
              b_d     = mdu_op[2] ? abs2 : abs1;
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!op_q[2]) begin
            {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
          end else if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) state_d = S_FIX;
        end
        S_FIX: begin
          unique case (op_q)
            3'b000:                 result_d = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         result_d = quo;
            default:                result_d = rem;
          endcase
          state_d = S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments; every one is cleared by the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22041405_mdu.sv
// Self-checking bench for ysyx_22041405_mdu (WIDTH=32): directed vector table,
// randomized ops against an arithmetic reference, handshake/flush/reset sequences.
module tb_ysyx_22041405_mdu;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    mdu_op;
  logic [W-1:0]  src1, src2;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          busy;

  int errors = 0;
  int checks = 0;

  ysyx_22041405_mdu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mdu_op    (mdu_op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: plain 64-bit signed/unsigned arithmetic with the M-extension special cases.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = ua * ub;               return p[31:0];  end
      3'd1: begin p = sa * sb;               return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);     return p[63:32]; end
      3'd3: begin p = ua * ub;               return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (ovf)    return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return '0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return W + 2;
  endfunction

  // Issues one request, scrambles the inputs after acceptance, and returns the result
  // and the cycle (accept cycle = 0) in which out_valid was first seen.
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat);
    @(negedge clk);
    check("in_ready before request", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b1;
    mdu_op   = op;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mdu_op   = 3'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  vec_t         vecs[13];
  logic [W-1:0] res, held;
  int           lat, seen;
  logic [2:0]   rop;
  logic [W-1:0] ra, rb;

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mdu_op    = '0;
    src1      = '0;
    src2      = '0;

    vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 34};
    vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 34};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[3]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[4]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[5]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[6]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[7]  = '{3'b101, 32'd100,       32'd7,         32'd14,        34};
    vecs[8]  = '{3'b111, 32'd100,       32'd7,         32'd2,         34};
    vecs[9]  = '{3'b101, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[10] = '{3'b110, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1};
    vecs[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};

    #12;
    check("reset in_ready",  {63'b0, in_ready},  64'd1);
    check("reset out_valid", {63'b0, out_valid}, 64'd0);
    check("reset busy",      {63'b0, busy},      64'd0);
    check("reset result",    {32'b0, result},    64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i),  {32'b0, res}, {32'b0, vecs[i].exp});
      check($sformatf("vec%0d latency", i), 64'(lat),     64'(vecs[i].lat));
      consume();
    end

    for (int n = 0; n < 200; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       begin ra = 32'h8000_0000; rb = '1; end
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, res, lat);
      check($sformatf("rand%0d op%0d %h,%h result", n, rop, ra, rb), {32'b0, res}, {32'b0, ref_model(rop, ra, rb)});
      check($sformatf("rand%0d latency", n), 64'(lat), 64'(ref_lat(rop, ra, rb)));
      consume();
    end

    // Backpressure: result and in_ready hold while out_ready stays low.
    do_op(3'b000, 32'h1234_5678, 32'h0000_0010, held, lat);
    check("bp initial result", {32'b0, held}, {32'b0, ref_model(3'b000, 32'h1234_5678, 32'h0000_0010)});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d result stable", c), {32'b0, result}, {32'b0, held});
      check($sformatf("bp%0d in_ready", c),      {63'b0, in_ready},  64'd0);
      check($sformatf("bp%0d out_valid", c),     {63'b0, out_valid}, 64'd1);
    end
    consume();
    check("bp release in_ready",  {63'b0, in_ready},  64'd1);
    check("bp release out_valid", {63'b0, out_valid}, 64'd0);

    // Flush during cycle 10 of a DIV.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = 3'b100; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    check("flush busy before", {63'b0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush in_ready", {63'b0, in_ready}, 64'd1);
    check("flush busy",     {63'b0, busy},     64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush no out_valid", 64'(seen), 64'd0);

    // Flush together with in_valid in IDLE drops the request.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; mdu_op = 3'b101; src1 = 32'd9; src2 = 32'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid busy", {63'b0, busy}, 64'd0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush+valid dropped", 64'(seen), 64'd0);

    // Async reset mid-CALC; result is still nonzero from the backpressure op.
    @(negedge clk);
    in_valid = 1'b1; mdu_op = 3'b011; src1 = $urandom; src2 = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-reset busy", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", {63'b0, out_valid}, 64'd0);
    check("async rst result",    {32'b0, result},    64'd0);
    check("async rst in_ready",  {63'b0, in_ready},  64'd1);
    check("async rst busy",      {63'b0, busy},      64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(3'b111, 32'd100, 32'd7, res, lat);
    check("post-reset REMU", {32'b0, res}, 64'd2);
    consume();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
